// File: rtl/branch_resolve.sv
// -----------------------------------------------------------------------------
// branch_resolve
//
// Execute-stage branch resolution. Takes the comparator's {G, equal, S}
// result plus the branch's funct3, PC, offset and fetch prediction, and
// produces a registered decision: taken, target, redirect PC, mispredict,
// misalignment and illegal-encoding flags. It also steers the comparator's
// signed/unsigned select from funct3, and keeps saturating counts of legal
// branches and of legal mispredicted branches.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   flush               kill the held result and any input offered this cycle
//   in_valid/in_ready   upstream handshake
//   funct3, ges, pc,
//   imm, pred_taken     branch descriptor
//   cmp_sign            comparator signed-select (combinational)
//   out_valid/out_ready downstream handshake
//   out_taken, out_target, out_redirect_pc, out_mispredict,
//   out_misalign, out_illegal   registered result fields
//   branch_cnt, mispred_cnt     saturating performance counters
// -----------------------------------------------------------------------------
module branch_resolve #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,

    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       funct3,
    input  logic [2:0]       ges,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  imm,
    input  logic             pred_taken,

    output logic             cmp_sign,

    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_taken,
    output logic [XLEN-1:0]  out_target,
    output logic [XLEN-1:0]  out_redirect_pc,
    output logic             out_mispredict,
    output logic             out_misalign,
    output logic             out_illegal,

    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    // RV32I branch funct3 encodings
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam int NUM_CNT = 2;

    // Comparator result fields. G is not needed: every branch condition is
    // expressible with equal and S alone.
    logic ges_equal;
    logic ges_less;
    logic unused_ges_greater;

    assign unused_ges_greater = ges[2];
    assign ges_equal          = ges[1];
    assign ges_less           = ges[0];

    // Bit 1 of funct3 separates the unsigned compares (11x) from the signed
    // ones (10x). BEQ/BNE don't care but get the same formula.
    assign cmp_sign = ~funct3[1];

    // -------------------------------------------------------------------------
    // Result computation for the branch currently offered
    // -------------------------------------------------------------------------
    logic            taken_next;
    logic            illegal_next;
    logic [XLEN-1:0] target_next;
    logic [XLEN-1:0] seq_pc_next;
    logic [XLEN-1:0] redirect_next;
    logic            mispredict_next;
    logic            misalign_next;

    always_comb begin
        taken_next   = 1'b0;
        illegal_next = 1'b0;
        case (funct3)
            F3_BEQ:           taken_next = ges_equal;
            F3_BNE:           taken_next = ~ges_equal;
            F3_BLT, F3_BLTU:  taken_next = ges_less;
            F3_BGE, F3_BGEU:  taken_next = ~ges_less;
            default:          illegal_next = 1'b1;  // 010 / 011
        endcase
    end

    // Both adds wrap modulo 2^XLEN; the carry out is intentionally dropped.
    assign target_next     = pc + imm;
    assign seq_pc_next     = pc + XLEN'(4);
    assign redirect_next   = taken_next ? target_next : seq_pc_next;
    // Illegal branches resolve not-taken, so a taken prediction still counts
    // as a mispredict on the output flag.
    assign mispredict_next = taken_next ^ pred_taken;
    assign misalign_next   = taken_next & (target_next[1:0] != 2'b00);

    // -------------------------------------------------------------------------
    // Handshake
    // -------------------------------------------------------------------------
    logic out_valid_reg;
    logic out_valid_next;
    logic accept;

    assign in_ready = ~rst & (~out_valid_reg | out_ready);
    assign accept   = in_valid & in_ready & ~flush;

    always_comb begin
        out_valid_next = out_valid_reg;
        if (flush) begin
            out_valid_next = 1'b0;
        end else if (accept) begin
            out_valid_next = 1'b1;
        end else if (out_ready) begin
            out_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
        end else begin
            out_valid_reg <= out_valid_next;
        end
    end

    // -------------------------------------------------------------------------
    // Result register: loads only on accept, otherwise holds, which keeps the
    // fields stable while the consumer stalls.
    // -------------------------------------------------------------------------
    logic            taken_reg;
    logic [XLEN-1:0] target_reg;
    logic [XLEN-1:0] redirect_reg;
    logic            mispredict_reg;
    logic            misalign_reg;
    logic            illegal_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            taken_reg      <= 1'b0;
            target_reg     <= '0;
            redirect_reg   <= '0;
            mispredict_reg <= 1'b0;
            misalign_reg   <= 1'b0;
            illegal_reg    <= 1'b0;
        end else if (accept) begin
            taken_reg      <= taken_next;
            target_reg     <= target_next;
            redirect_reg   <= redirect_next;
            mispredict_reg <= mispredict_next;
            misalign_reg   <= misalign_next;
            illegal_reg    <= illegal_next;
        end
    end

    assign out_valid       = out_valid_reg;
    assign out_taken       = taken_reg;
    assign out_target      = target_reg;
    assign out_redirect_pc = redirect_reg;
    assign out_mispredict  = mispredict_reg;
    assign out_misalign    = misalign_reg;
    assign out_illegal     = illegal_reg;

    // -------------------------------------------------------------------------
    // Performance counters. Slot 0 counts accepted legal branches, slot 1
    // counts the mispredicted subset. Each sticks at all-ones.
    // -------------------------------------------------------------------------
    logic [NUM_CNT-1:0]            cnt_inc;
    logic [NUM_CNT-1:0][CNT_W-1:0] cnt_val;

    assign cnt_inc[0] = accept & ~illegal_next;
    assign cnt_inc[1] = accept & ~illegal_next & mispredict_next;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W-1:0] cnt_next;

            always_comb begin
                cnt_next = cnt_reg;
                if (cnt_inc[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_next;
                end
            end

            assign cnt_val[gi] = cnt_reg;
        end
    endgenerate

    assign branch_cnt  = cnt_val[0];
    assign mispred_cnt = cnt_val[1];

endmodule

// File: tb/tb_branch_resolve.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve
//
// Drives two instances (16-bit and 4-bit counters) with identical stimulus:
// directed steps followed by a random phase. A behavioural model tracks the
// expected result register and counter totals from the branch rules.
// -----------------------------------------------------------------------------
module tb_branch_resolve;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, in_valid, out_ready, pred_taken;
    logic [2:0]  funct3, ges;
    logic [31:0] pc, imm;

    logic        in_ready, cmp_sign, out_valid, out_taken;
    logic [31:0] out_target, out_redirect_pc;
    logic        out_mispredict, out_misalign, out_illegal;
    logic [15:0] branch_cnt, mispred_cnt;

    logic        in_ready4, cmp_sign4, out_valid4, out_taken4;
    logic [31:0] out_target4, out_redirect_pc4;
    logic        out_mispredict4, out_misalign4, out_illegal4;
    logic [3:0]  branch_cnt4, mispred_cnt4;

    branch_resolve #(.XLEN(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .funct3(funct3), .ges(ges), .pc(pc), .imm(imm), .pred_taken(pred_taken),
        .cmp_sign(cmp_sign),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_taken(out_taken), .out_target(out_target),
        .out_redirect_pc(out_redirect_pc), .out_mispredict(out_mispredict),
        .out_misalign(out_misalign), .out_illegal(out_illegal),
        .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    branch_resolve #(.XLEN(32), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready4),
        .funct3(funct3), .ges(ges), .pc(pc), .imm(imm), .pred_taken(pred_taken),
        .cmp_sign(cmp_sign4),
        .out_valid(out_valid4), .out_ready(out_ready),
        .out_taken(out_taken4), .out_target(out_target4),
        .out_redirect_pc(out_redirect_pc4), .out_mispredict(out_mispredict4),
        .out_misalign(out_misalign4), .out_illegal(out_illegal4),
        .branch_cnt(branch_cnt4), .mispred_cnt(mispred_cnt4)
    );

    int n_pass = 0;
    int n_total = 0;

    // model state
    bit          m_valid, m_def;
    bit          m_taken, m_mis, m_misal, m_ill;
    logic [31:0] m_target, m_redir;
    int          m_bcnt, m_mcnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    function automatic bit ref_taken(input logic [2:0] f, input logic [2:0] g);
        // g = {G, equal, S}
        case (f)
            3'd0:       return g[1];
            3'd1:       return !g[1];
            3'd4, 3'd6: return g[0];
            3'd5, 3'd7: return !g[0];
            default:    return 1'b0;
        endcase
    endfunction

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    // One clock cycle: apply inputs, check combinational outputs, advance the
    // model, clock, check registered outputs.
    task automatic step(input bit r, input bit fl, input bit iv, input bit orr,
                        input logic [2:0] f, input logic [2:0] g,
                        input logic [31:0] p, input logic [31:0] i, input bit pt);
        bit exp_ready, t;
        logic [31:0] tgt;
        rst = r; flush = fl; in_valid = iv; out_ready = orr;
        funct3 = f; ges = g; pc = p; imm = i; pred_taken = pt;
        #1;
        exp_ready = !r && (!m_valid || orr);
        chk("in_ready", {63'd0, in_ready}, {63'd0, exp_ready});
        chk("in_ready4", {63'd0, in_ready4}, {63'd0, exp_ready});
        chk("cmp_sign", {63'd0, cmp_sign}, {63'd0, (f == 3'd4 || f == 3'd5 || f[2] == 1'b0) ? !f[1] : 1'b0});

        if (r) begin
            m_valid = 0; m_def = 1; m_taken = 0; m_mis = 0; m_misal = 0; m_ill = 0;
            m_target = 0; m_redir = 0; m_bcnt = 0; m_mcnt = 0;
        end else if (fl) begin
            m_valid = 0; m_def = 0;
        end else if (iv && exp_ready) begin
            t        = ref_taken(f, g);
            tgt      = p + i;
            m_taken  = t;
            m_target = tgt;
            m_redir  = t ? tgt : p + 32'd4;
            m_mis    = (t != pt);
            m_misal  = t && (tgt % 4 != 0);
            m_ill    = (f == 3'd2 || f == 3'd3);
            m_valid  = 1; m_def = 1;
            if (!m_ill) begin
                m_bcnt++;
                if (m_mis) m_mcnt++;
            end
        end else if (m_valid && orr) begin
            m_valid = 0; m_def = 0;
        end

        @(posedge clk);
        #1;
        chk("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
        chk("out_valid4", {63'd0, out_valid4}, {63'd0, m_valid});
        if (m_def) begin
            chk("out_taken", {63'd0, out_taken}, {63'd0, m_taken});
            chk("out_target", {32'd0, out_target}, {32'd0, m_target});
            chk("out_redirect_pc", {32'd0, out_redirect_pc}, {32'd0, m_redir});
            chk("out_mispredict", {63'd0, out_mispredict}, {63'd0, m_mis});
            chk("out_misalign", {63'd0, out_misalign}, {63'd0, m_misal});
            chk("out_illegal", {63'd0, out_illegal}, {63'd0, m_ill});
        end
        chk("branch_cnt", {48'd0, branch_cnt}, 64'(sat(m_bcnt, 65535)));
        chk("mispred_cnt", {48'd0, mispred_cnt}, 64'(sat(m_mcnt, 65535)));
        chk("branch_cnt4", {60'd0, branch_cnt4}, 64'(sat(m_bcnt, 15)));
        chk("mispred_cnt4", {60'd0, mispred_cnt4}, 64'(sat(m_mcnt, 15)));
    endtask

    task automatic idle(input bit orr);
        step(0, 0, 0, orr, 3'd0, 3'b010, 32'd0, 32'd0, 0);
    endtask

    initial begin
        logic [2:0] ges_set [3];
        logic [2:0] legal_f3 [6];
        logic [31:0] held_target;
        ges_set[0] = 3'b100; ges_set[1] = 3'b010; ges_set[2] = 3'b001;
        legal_f3[0] = 3'd0; legal_f3[1] = 3'd1; legal_f3[2] = 3'd4;
        legal_f3[3] = 3'd5; legal_f3[4] = 3'd6; legal_f3[5] = 3'd7;

        // reset
        step(1, 0, 0, 1, 3'd0, 3'b010, 32'd0, 32'd0, 0);
        step(1, 0, 1, 1, 3'd0, 3'b010, 32'd0, 32'd0, 0);
        idle(1);

        // BEQ taken, predicted not-taken
        step(0, 0, 1, 1, 3'd0, 3'b010, 32'h100, 32'h20, 0);
        chk("beq_target", {32'd0, out_target}, 64'h120);
        chk("beq_redirect", {32'd0, out_redirect_pc}, 64'h120);
        chk("beq_mispredict", {63'd0, out_mispredict}, 64'd1);
        chk("beq_branch_cnt", {48'd0, branch_cnt}, 64'd1);
        chk("beq_mispred_cnt", {48'd0, mispred_cnt}, 64'd1);

        // decode sweep, back-to-back
        for (int fi = 0; fi < 6; fi++) begin
            for (int gj = 0; gj < 3; gj++) begin
                step(0, 0, 1, 1, legal_f3[fi], ges_set[gj], $urandom, $urandom, 1'($urandom));
            end
        end
        idle(1);

        // backpressure: one result held, three stalled cycles, then no-bubble accept
        step(0, 0, 1, 0, 3'd4, 3'b001, 32'h2000, 32'h40, 1);
        held_target = out_target;
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 1, 0, 3'd5, 3'b001, 32'h3000, 32'h80, 0);
            chk("held_target", {32'd0, out_target}, {32'd0, held_target});
        end
        step(0, 0, 1, 1, 3'd5, 3'b001, 32'h3000, 32'h80, 0);
        chk("after_stall_target", {32'd0, out_target}, 64'h3080);

        // wrap-around cases
        step(0, 0, 1, 1, 3'd1, 3'b010, 32'hFFFF_FFFC, 32'h100, 0);
        chk("wrap_redirect", {32'd0, out_redirect_pc}, 64'h0);
        step(0, 0, 1, 1, 3'd0, 3'b010, 32'h10, 32'hFFFF_FFF2, 1);
        chk("wrap_target", {32'd0, out_target}, 64'h2);
        chk("wrap_misalign", {63'd0, out_misalign}, 64'd1);

        // flush with a held result and a same-cycle input
        step(0, 0, 1, 0, 3'd0, 3'b010, 32'h400, 32'h8, 1);
        step(0, 1, 1, 0, 3'd0, 3'b010, 32'h500, 32'h8, 0);
        idle(1);

        // illegal encodings
        step(0, 0, 1, 1, 3'd2, 3'b010, 32'h600, 32'h10, 1);
        chk("illegal_flag", {63'd0, out_illegal}, 64'd1);
        chk("illegal_taken", {63'd0, out_taken}, 64'd0);
        step(0, 0, 1, 1, 3'd3, 3'b001, 32'h700, 32'h10, 0);

        // random phase
        for (int n = 0; n < 300; n++) begin
            step(($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 10),
                 ($urandom_range(0, 99) < 70), ($urandom_range(0, 99) < 70),
                 3'($urandom), ges_set[$urandom_range(0, 2)],
                 $urandom, $urandom, 1'($urandom));
        end

        // saturation of the 4-bit counters
        step(1, 0, 0, 1, 3'd0, 3'b010, 32'd0, 32'd0, 0);
        for (int n = 0; n < 20; n++) begin
            step(0, 0, 1, 1, 3'd4, 3'b100, 32'h1000 + 32'(n * 4), 32'h40, 1);
        end
        chk("sat_branch_cnt4", {60'd0, branch_cnt4}, 64'd15);
        chk("sat_mispred_cnt4", {60'd0, mispred_cnt4}, 64'd15);
        chk("nosat_branch_cnt", {48'd0, branch_cnt}, 64'd20);
        step(0, 0, 1, 1, 3'd4, 3'b100, 32'h2000, 32'h40, 1);
        idle(1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
